// File: rtl/izh_if.sv
// izh_if: step request / readout bus between the controller and the Izhikevich neuron array.
interface izh_if #(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int IW = 8
);
  logic                  step;
  logic [1:0]            mode;
  logic [N*IW-1:0]       current;
  logic [$clog2(N)-1:0]  v_sel;
  logic                  busy;
  logic                  step_done;
  logic [N-1:0]          spike;
  logic signed [W-1:0]   v_out;
  modport master (output step, mode, current, v_sel, input busy, step_done, spike, v_out);
  modport slave  (input step, mode, current, v_sel, output busy, step_done, spike, v_out);
endinterface

// File: rtl/izh_array.sv
// izh_array: N Izhikevich neurons time-multiplexed over one saturating fixed-point Euler datapath.
module izh_array #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int IW       = 8,
  parameter int DT_SHIFT = 1
) (
  input  logic clk,
  input  logic reset_n,
  izh_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int XW = 2*W + 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic signed [W-1:0]  word_t;
  typedef logic signed [XW-1:0] wide_t;
  localparam word_t V_RST = word_t'(-65 * (2**FRAC));
  localparam word_t U_RST = word_t'(-13 * (2**FRAC));
  localparam wide_t VMAX  = wide_t'(2**(W-1) - 1);
  localparam wide_t VMIN  = wide_t'(-(2**(W-1)));
  localparam wide_t VTH   = wide_t'(30 * (2**FRAC));

  state_t          state_q, state_d;
  logic [SW-1:0]   idx_q, idx_d, sel;
  logic [1:0]      mode_q, mode_d;
  logic [N*IW-1:0] cur_q, cur_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [N-1:0]    spike_q, spike_d, sh_q, sh_d;
  word_t           v_q [N];
  word_t           v_d [N];
  word_t           u_q [N];
  word_t           u_d [N];
  word_t           v_out_q, v_out_d;

  wide_t vx, ux, ix, vv, t, cx, dx;
  word_t vn, un, us;
  logic  fire;
  int    a_sh, c_mv, d_mv;

  function automatic word_t sat(input wide_t x);
    return x > VMAX ? word_t'(VMAX) : x < VMIN ? word_t'(VMIN) : word_t'(x);
  endfunction

  always_comb begin
    a_sh = mode_q == 2'd1 ? 3 : 6;
    c_mv = mode_q[1] ? (mode_q[0] ? -55 : -50) : -65;
    d_mv = mode_q == 2'd0 ? 8 : mode_q == 2'd3 ? 4 : 2;
    vx   = wide_t'(v_q[idx_q]);
    ux   = wide_t'(u_q[idx_q]);
    ix   = wide_t'(cur_q[idx_q*IW +: IW]);
    vv   = (vx * vx) >>> FRAC;
    t    = ((vv * wide_t'(41)) >>> 10) + vx * wide_t'(5) + (wide_t'(140) <<< FRAC) - ux + (ix <<< FRAC);
    vn   = sat(vx + (t >>> DT_SHIFT));
    un   = sat(ux + ((((vx * wide_t'(13)) >>> 6) - ux) >>> (a_sh + DT_SHIFT)));
    cx   = wide_t'(c_mv) <<< FRAC;
    dx   = wide_t'(d_mv) <<< FRAC;
    fire = wide_t'(vn) >= VTH;
    us   = sat(wide_t'(un) + dx);
    sel  = ({1'b0, bus.v_sel} < (SW+1)'(N)) ? bus.v_sel : '0;
    v_out_d = v_q[sel];
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    cur_d   = cur_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    spike_d = spike_q;
    sh_d    = sh_q;
    v_d     = v_q;
    u_d     = u_q;
    if (state_q == IDLE && bus.step) begin
      state_d = RUN;
      idx_d   = '0;
      mode_d  = bus.mode;
      cur_d   = bus.current;
      busy_d  = 1'b1;
    end
    if (state_q == RUN) begin
      v_d[idx_q]  = fire ? word_t'(cx) : vn;
      u_d[idx_q]  = fire ? us : un;
      sh_d[idx_q] = fire;
      idx_d       = idx_q + 1'b1;
      state_d     = idx_q == SW'(N-1) ? DONE : RUN;
    end
    if (state_q == DONE) begin
      done_d  = 1'b1;
      spike_d = sh_q;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= '0;
      cur_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      spike_q <= '0;
      sh_q    <= '0;
      v_q     <= '{default: V_RST};
      u_q     <= '{default: U_RST};
      v_out_q <= V_RST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      spike_q <= spike_d;
      sh_q    <= sh_d;
      v_q     <= v_d;
      u_q     <= u_d;
      v_out_q <= v_out_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.step_done = done_q;
  assign bus.spike     = spike_q;
  assign bus.v_out     = v_out_q;
endmodule
